// File: rtl/adc_spi_sequencer.sv
// Scans enabled ADC channels over SPI with a one-frame pipeline, streaming results out.
// Optional lost-result detection is enabled with the ADC_SEQ_OVERRUN_EN macro.
module adc_spi_sequencer #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CLK_DIV     = 250,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode_cont,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 adc_convst,
    output logic                 adc_sck,
    output logic                 adc_sdi,
    input  logic                 adc_sdo,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [11:0]          res_data,
    output logic [2:0]           res_ch,
    output logic [NUM_CH*12-1:0] result_all,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned CntMax = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StConv, StXfer, StEmit} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;
    logic                convst_q, convst_d;
    logic [11:0]         shift_q, shift_d;
    logic [2:0]          cfg_ch_q, cfg_ch_d;
    logic [2:0]          tag_ch_q, tag_ch_d;
    logic                prime_q, prime_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                cont_q, cont_d;
    logic [3:0]          left_q, left_d;
    logic                stop_pend_q, stop_pend_d;
    logic                res_valid_q, res_valid_d;
    logic [11:0]         res_data_q, res_data_d;
    logic [2:0]          res_ch_q, res_ch_d;
    logic [NUM_CH*12-1:0] result_all_q, result_all_d;

    logic        start_ok;
    logic        stop_now;
    logic        new_frame;
    logic [11:0] cfg_word;

    function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (m[j]) r = 3'(j);
        end
        return r;
    endfunction

    // Next enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic       found;
        r     = first_ch(m);
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && m[j] && j > int'(cur)) begin
                r     = 3'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign start_ok = (state_q == StIdle) && start && (ch_mask != '0);
    assign stop_now = stop_pend_q | stop;
    assign cfg_word = {1'b1, cfg_ch_q[0], cfg_ch_q[2], cfg_ch_q[1], 2'b10, 6'b0};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;
        convst_d     = convst_q;
        shift_d      = shift_q;
        cfg_ch_d     = cfg_ch_q;
        tag_ch_d     = tag_ch_q;
        prime_d      = prime_q;
        mask_d       = mask_q;
        cont_d       = cont_q;
        left_d       = left_q;
        stop_pend_d  = stop_pend_q;
        res_valid_d  = res_valid_q & ~res_ready;
        res_data_d   = res_data_q;
        res_ch_d     = res_ch_q;
        result_all_d = result_all_q;
        new_frame    = 1'b0;

        if (state_q != StIdle && stop) stop_pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d     = StConv;
                    convst_d    = 1'b1;
                    cnt_d       = '0;
                    cfg_ch_d    = first_ch(ch_mask);
                    mask_d      = ch_mask;
                    cont_d      = mode_cont;
                    left_d      = 4'($countones(ch_mask));
                    prime_d     = 1'b1;
                    stop_pend_d = 1'b0;
                end
            end
            StConv: begin
                if (cnt_q == CntW'(CONV_CYCLES - 1)) begin
                    state_d  = StXfer;
                    convst_d = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    sck_d    = 1'b0;
                    sdi_d    = cfg_word[11];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StXfer: begin
                if (cnt_q == CntW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        shift_d = {shift_q[10:0], adc_sdo};
                    end else if (bit_q == 4'd11) begin
                        sdi_d = 1'b0;
                        // Priming frame: data belongs to no configured channel, discard it.
                        if (prime_q) begin
                            prime_d = 1'b0;
                            if (stop_now) state_d = StIdle;
                            else          new_frame = 1'b1;
                        end else begin
                            state_d = StEmit;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sdi_d = cfg_word[4'd10 - bit_q];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEmit: begin
                res_valid_d = 1'b1;
                res_data_d  = shift_q;
                res_ch_d    = tag_ch_q;
                for (int j = 0; j < NUM_CH; j++) begin
                    if (tag_ch_q == 3'(j)) result_all_d[j*12 +: 12] = shift_q;
                end
                if (!cont_q) left_d = left_q - 4'd1;
                if (stop_now || (!cont_q && left_q == 4'd1)) state_d = StIdle;
                else                                          new_frame = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Result read in a frame belongs to the channel configured one frame earlier.
        if (new_frame) begin
            state_d  = StConv;
            convst_d = 1'b1;
            cnt_d    = '0;
            tag_ch_d = cfg_ch_q;
            cfg_ch_d = next_ch(mask_q, cfg_ch_q);
        end

        if (state_d == StIdle) stop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
            convst_q     <= 1'b0;
            shift_q      <= '0;
            cfg_ch_q     <= '0;
            tag_ch_q     <= '0;
            prime_q      <= 1'b0;
            mask_q       <= '0;
            cont_q       <= 1'b0;
            left_q       <= '0;
            stop_pend_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_ch_q     <= '0;
            result_all_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
            convst_q     <= convst_d;
            shift_q      <= shift_d;
            cfg_ch_q     <= cfg_ch_d;
            tag_ch_q     <= tag_ch_d;
            prime_q      <= prime_d;
            mask_q       <= mask_d;
            cont_q       <= cont_d;
            left_q       <= left_d;
            stop_pend_q  <= stop_pend_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            result_all_q <= result_all_d;
        end
    end

`ifdef ADC_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (start_ok)                                              overrun_d = 1'b0;
        else if (state_q == StEmit && res_valid_q && !res_ready)   overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ch     = res_ch_q;
    assign result_all = result_all_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed bench for adc_spi_sequencer with a frame-aware SPI ADC model and pin monitors.
module tb_adc_spi_sequencer;

    localparam int unsigned NCH  = 8;
    localparam int unsigned CDIV = 3;
    localparam int unsigned CONV = 10;
`ifdef ADC_SEQ_OVERRUN_EN
    localparam logic OvrExp = 1'b1;
`else
    localparam logic OvrExp = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
    logic res_ready = 1'b1;
    logic [NCH-1:0] ch_mask = '0;
    logic adc_convst, adc_sck, adc_sdi, adc_sdo, res_valid, busy, overrun;
    logic [11:0] res_data;
    logic [2:0]  res_ch;
    logic [NCH*12-1:0] result_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_spi_sequencer #(.NUM_CH(NCH), .CLK_DIV(CDIV), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_cont(mode_cont),
        .ch_mask(ch_mask), .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
        .adc_sdo(adc_sdo), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ch(res_ch), .result_all(result_all), .busy(busy), .overrun(overrun)
    );

    // Pin monitor, sampled on the falling clk edge.
    logic sck_p = 1'b0, cv_p = 1'b0;
    int fr_idx = 0, rise_n = 0, total_rises = 0, cv_len = 0, lo_len = 0, hi_len = 0;
    logic [11:0] sdi_sh = '0;
    logic [11:0] cfg_log[$];
    logic [14:0] emit_log[$];
    int conv_lens[$], lo_lens[$], hi_lens[$];

    always @(negedge clk) begin
        sck_p <= adc_sck;
        cv_p  <= adc_convst;
        if (adc_convst && !cv_p) begin
            fr_idx <= fr_idx + 1;
            rise_n <= 0;
        end
        if (adc_convst) cv_len <= cv_len + 1;
        else if (cv_p) begin
            conv_lens.push_back(cv_len);
            cv_len <= 0;
        end
        if (adc_sck) begin
            if (!sck_p) begin
                lo_lens.push_back(lo_len);
                hi_len      <= 1;
                sdi_sh      <= {sdi_sh[10:0], adc_sdi};
                rise_n      <= rise_n + 1;
                total_rises <= total_rises + 1;
                if (rise_n == 11) cfg_log.push_back({sdi_sh[10:0], adc_sdi});
            end else begin
                hi_len <= hi_len + 1;
            end
        end else begin
            if (sck_p) begin
                hi_lens.push_back(hi_len);
                lo_len <= 1;
            end else if (adc_convst) lo_len <= 0;
            else lo_len <= lo_len + 1;
        end
        if (res_valid) emit_log.push_back({res_ch, res_data});
    end

    // ADC model: frame k of a scan returns sdo_base + (k-2)*0x111, MSB first.
    int fr_base = 0;
    logic [11:0] sdo_base = '0;
    logic [11:0] sdo_word;
    always_comb begin
        sdo_word = sdo_base + 12'((fr_idx - fr_base - 2) * 273);
        adc_sdo  = (rise_n >= 0 && rise_n < 12) ? sdo_word[11 - rise_n] : 1'b0;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] emit_at(input int i);
        return (i < emit_log.size()) ? emit_log[i] : 15'hxxxx;
    endfunction

    function automatic logic [11:0] cfg_at(input int i);
        return (i < cfg_log.size()) ? cfg_log[i] : 12'hxxx;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (busy && k < max_cyc);
        check("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic wait_frames(input int n, input int max_cyc);
        int k = 0;
        while (fr_idx - fr_base < n && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        check("frame_timeout", 128'(fr_idx - fr_base >= n), 128'(1));
    endtask

    int e0, c0, r0, cl0, l0, h0, k;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_convst", 128'(adc_convst), 128'(0));
        check("rst_sck", 128'(adc_sck), 128'(0));
        check("rst_sdi", 128'(adc_sdi), 128'(0));
        check("rst_valid", 128'(res_valid), 128'(0));
        check("rst_data", 128'(res_data), 128'(0));
        check("rst_ch", 128'(res_ch), 128'(0));
        check("rst_all", 128'(result_all), 128'(0));
        check("rst_overrun", 128'(overrun), 128'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Single channel 0: priming frame plus one emitting frame
        mode_cont = 1'b0; ch_mask = 8'h01; sdo_base = 12'hA5C; fr_base = fr_idx;
        e0 = emit_log.size(); c0 = cfg_log.size(); r0 = total_rises;
        cl0 = conv_lens.size(); l0 = lo_lens.size(); h0 = hi_lens.size();
        pulse_start();
        check("t1_busy", 128'(busy), 128'(1));
        wait_idle(400);
        repeat (3) @(posedge clk);
        #1;
        check("t1_frames", 128'(fr_idx - fr_base), 128'(2));
        check("t1_emits", 128'(emit_log.size() - e0), 128'(1));
        check("t1_emit0", 128'(emit_at(e0)), 128'({3'd0, 12'hA5C}));
        check("t1_cfg0", 128'(cfg_at(c0)), 128'(12'h880));
        check("t1_cfg1", 128'(cfg_at(c0 + 1)), 128'(12'h880));
        check("t1_slot0", 128'(result_all[11:0]), 128'(12'hA5C));
        check("t1_res", 128'({res_ch, res_data}), 128'({3'd0, 12'hA5C}));
        check("t1_valid_acked", 128'(res_valid), 128'(0));
        check("t1_rises", 128'(total_rises - r0), 128'(24));
        check("t1_nconv", 128'(conv_lens.size() - cl0), 128'(2));
        for (int i = cl0; i < conv_lens.size(); i++) check("t1_convst_len", 128'(conv_lens[i]), 128'(10));
        check("t1_nlo", 128'(lo_lens.size() - l0), 128'(24));
        for (int i = l0; i < lo_lens.size(); i++) check("t1_sck_low", 128'(lo_lens[i]), 128'(3));
        check("t1_nhi", 128'(hi_lens.size() - h0), 128'(24));
        for (int i = h0; i < hi_lens.size(); i++) check("t1_sck_high", 128'(hi_lens[i]), 128'(3));

        // Start with empty mask is ignored
        ch_mask = '0; fr_base = fr_idx;
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check("t2_empty_busy", 128'(busy), 128'(0));
        check("t2_empty_frames", 128'(fr_idx - fr_base), 128'(0));

        // Mask 1010_0100 single pass, with mask/mode/start changes while busy
        ch_mask = 8'hA4; sdo_base = 12'h123; fr_base = fr_idx;
        e0 = emit_log.size(); c0 = cfg_log.size(); r0 = total_rises;
        pulse_start();
        ch_mask = 8'hFF; mode_cont = 1'b1;
        repeat (30) @(posedge clk);
        pulse_start();
        wait_idle(600);
        repeat (3) @(posedge clk);
        #1;
        check("t3_frames", 128'(fr_idx - fr_base), 128'(4));
        check("t3_cfg0", 128'(cfg_at(c0)), 128'(12'h980));
        check("t3_cfg1", 128'(cfg_at(c0 + 1)), 128'(12'hE80));
        check("t3_cfg2", 128'(cfg_at(c0 + 2)), 128'(12'hF80));
        check("t3_cfg3", 128'(cfg_at(c0 + 3)), 128'(12'h980));
        check("t3_emits", 128'(emit_log.size() - e0), 128'(3));
        check("t3_emit0", 128'(emit_at(e0)), 128'({3'd2, 12'h123}));
        check("t3_emit1", 128'(emit_at(e0 + 1)), 128'({3'd5, 12'h234}));
        check("t3_emit2", 128'(emit_at(e0 + 2)), 128'({3'd7, 12'h345}));
        check("t3_all", 128'(result_all),
              128'({12'h345, 12'h000, 12'h234, 12'h000, 12'h000, 12'h123, 12'h000, 12'hA5C}));
        check("t3_rises", 128'(total_rises - r0), 128'(48));

        // Continuous over ch0/ch1, stop during XFER of frame 5
        mode_cont = 1'b1; ch_mask = 8'h03; sdo_base = 12'h400; fr_base = fr_idx;
        e0 = emit_log.size(); c0 = cfg_log.size();
        pulse_start();
        mode_cont = 1'b0;
        wait_frames(5, 800);
        k = 0;
        while (adc_convst && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_in_xfer", 128'(adc_convst), 128'(0));
        repeat (20) @(posedge clk);
        pulse_stop();
        wait_idle(300);
        repeat (3) @(posedge clk);
        #1;
        check("t4_emits", 128'(emit_log.size() - e0), 128'(4));
        check("t4_emit0", 128'(emit_at(e0)), 128'({3'd0, 12'h400}));
        check("t4_emit1", 128'(emit_at(e0 + 1)), 128'({3'd1, 12'h511}));
        check("t4_emit2", 128'(emit_at(e0 + 2)), 128'({3'd0, 12'h622}));
        check("t4_emit3", 128'(emit_at(e0 + 3)), 128'({3'd1, 12'h733}));
        check("t4_cfg1", 128'(cfg_at(c0 + 1)), 128'(12'hC80));
        check("t4_cfg4", 128'(cfg_at(c0 + 4)), 128'(12'h880));
        check("t4_slots01", 128'(result_all[23:0]), 128'({12'h733, 12'h622}));
        repeat (200) @(posedge clk);
        #1;
        check("t4_no_more_frames", 128'(fr_idx - fr_base), 128'(5));
        check("t4_busy", 128'(busy), 128'(0));

        // Back-pressure: two emits with res_ready low
        res_ready = 1'b0; mode_cont = 1'b0; ch_mask = 8'h18; sdo_base = 12'h7E0; fr_base = fr_idx;
        pulse_start();
        wait_idle(500);
        repeat (3) @(posedge clk);
        #1;
        check("t5_valid", 128'(res_valid), 128'(1));
        check("t5_data", 128'(res_data), 128'(12'h8F1));
        check("t5_ch", 128'(res_ch), 128'(4));
        check("t5_overrun", 128'(overrun), 128'(OvrExp));
        check("t5_slots34", 128'(result_all[59:36]), 128'({12'h8F1, 12'h7E0}));
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_valid_cleared", 128'(res_valid), 128'(0));

        // Reset mid-XFER, then restart needs a priming frame
        ch_mask = 8'h01; fr_base = fr_idx;
        pulse_start();
        check("t6_overrun_cleared", 128'(overrun), 128'(0));
        k = 0;
        while (!adc_sck && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_sck_high", 128'(adc_sck), 128'(1));
        #2 reset = 1'b1;
        #1;
        check("t6_rst_outputs",
              128'({busy, adc_convst, adc_sck, adc_sdi, res_valid, overrun, res_ch, res_data}),
              128'(0));
        check("t6_rst_all", 128'(result_all), 128'(0));
        @(posedge clk); #1 reset = 1'b0;
        ch_mask = 8'h02; sdo_base = 12'h5A5; fr_base = fr_idx; e0 = emit_log.size();
        pulse_start();
        wait_idle(400);
        repeat (3) @(posedge clk);
        #1;
        check("t6_frames", 128'(fr_idx - fr_base), 128'(2));
        check("t6_emits", 128'(emit_log.size() - e0), 128'(1));
        check("t6_emit0", 128'(emit_at(e0)), 128'({3'd1, 12'h5A5}));
        check("t6_all", 128'(result_all), 128'({12'h5A5, 12'h000}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
